// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the elastic pipeline stage registers
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } skid_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - elastic stage register with one-entry skid buffer,
// flush and saturating stall counter; in_ready is fully registered.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  skid_state_t      state;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // in_ready is computed as (next state != FULL) alongside each transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else if (flush) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (in_xfer) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          in_ready <= 1'b1;
          if (in_xfer && out_xfer) begin
            out_data <= in_data;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end else if (in_xfer) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
            state      <= FULL;
            in_ready   <= 1'b0;
          end
        end
        FULL: begin
          if (out_xfer) begin
            out_data   <= skid_data;
            out_valid  <= skid_valid;
            skid_valid <= 1'b0;
            state      <= BUSY;
            in_ready   <= 1'b1;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          state      <= EMPTY;
          out_valid  <= 1'b0;
          skid_valid <= 1'b0;
          in_ready   <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .clr(stat_clr),
    .inc(out_valid && !out_ready),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench for pipe_skid_reg
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, stat_clr;
  logic        in_ready, out_valid;
  logic [31:0] in_data, out_data;
  logic [15:0] stall_cnt;

  logic        flush2, in_valid2, out_ready2, stat_clr2;
  logic        in_ready2, out_valid2;
  logic [7:0]  in_data2, out_data2;
  logic [1:0]  stall_cnt2;

  int tests = 0;
  int fails = 0;

  // Reference model: occupancy queue (capacity 2) plus registered in_ready.
  logic [31:0] q[$];
  logic        m_in_ready;
  int          m_stall;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stat_clr(stat_clr), .stall_cnt(stall_cnt)
  );

  pipe_skid_reg #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .stat_clr(stat_clr2), .stall_cnt(stall_cnt2)
  );

  task automatic model_step();
    bit acc;
    if (rst) begin
      q.delete();
      m_in_ready = 1'b0;
      m_stall    = 0;
      m_data     = '0;
    end else begin
      if (stat_clr) m_stall = 0;
      else if (q.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
      if (flush) begin
        q.delete();
        m_in_ready = 1'b1;
      end else begin
        acc = in_valid && m_in_ready;
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back(in_data);
        m_in_ready = (q.size() < 2);
        if (q.size() > 0) m_data = q[0];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; in_valid = 1; in_data = 32'hDEADBEEF; out_ready = 1; stat_clr = 0;
    flush2 = 0; in_valid2 = 0; in_data2 = '0; out_ready2 = 1; stat_clr2 = 0;
    tick(); tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    tests++; if (stall_cnt !== 16'h0) begin fails++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    rst = 0;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_first_cycle_in_ready: got %b expected 0", in_ready); end
    tick();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL reset_second_cycle: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin fails++; $display("FAIL reset_first_accept: got valid=%b data=%h expected 1 deadbeef", out_valid, out_data); end
    in_valid = 0;
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_data = i;
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 32'(i) || in_ready !== 1'b1) begin
        fails++; $display("FAIL stream_%0d: got valid=%b data=%h in_ready=%b expected 1 %h 1", i, out_valid, out_data, in_ready, i);
      end
    end
    in_valid = 0;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL stream_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    in_valid = 1; in_data = 32'hA; out_ready = 1;
    tick();
    out_ready = 0; in_data = 32'hB;
    tick();
    tests++; if (in_ready !== 1'b0 || out_data !== 32'hA) begin fails++; $display("FAIL bp_skid: got in_ready=%b data=%h expected 0 a", in_ready, out_data); end
    in_data = 32'hC;
    tick(); tick();
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA || stall_cnt !== 16'd3) begin
      fails++; $display("FAIL bp_hold: got in_ready=%b valid=%b data=%h stall=%0d expected 0 1 a 3", in_ready, out_valid, out_data, stall_cnt);
    end
    out_ready = 1;
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin fails++; $display("FAIL bp_second: got valid=%b data=%h in_ready=%b expected 1 b 1", out_valid, out_data, in_ready); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 32'hC) begin fails++; $display("FAIL bp_third: got valid=%b data=%h expected 1 c", out_valid, out_data); end
    in_valid = 0;
    tick();
    tests++; if (out_valid !== 1'b0 || stall_cnt !== 16'd3) begin fails++; $display("FAIL bp_end: got valid=%b stall=%0d expected 0 3", out_valid, stall_cnt); end
    stat_clr = 1;
    tick();
    stat_clr = 0;
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL bp_stat_clr: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_prefill: got in_ready=%b expected 0", in_ready); end
    flush = 1; in_data = 32'h55;
    tick();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_next: got valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
    tests++; if (stall_cnt !== 16'd2) begin fails++; $display("FAIL flush_stall_cnt: got %0d expected 2", stall_cnt); end
    flush = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_55: got valid=%b data=%h expected valid 0", out_valid, out_data); end
    end
    stat_clr = 1;
    tick();
    stat_clr = 0;
  endtask

  task automatic test_stall_saturate();
    in_valid2 = 1; in_data2 = 8'h5A; out_ready2 = 1;
    tick();
    tests++; if (out_valid2 !== 1'b1 || out_data2 !== 8'h5A || in_ready2 !== 1'b1) begin
      fails++; $display("FAIL sat_load: got valid=%b data=%h in_ready=%b expected 1 5a 1", out_valid2, out_data2, in_ready2);
    end
    in_valid2 = 0; out_ready2 = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      tests++;
      if (stall_cnt2 !== 2'((k < 3) ? k : 3)) begin fails++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", k, stall_cnt2, (k < 3) ? k : 3); end
    end
    stat_clr2 = 1;
    tick();
    tests++; if (stall_cnt2 !== 2'd0) begin fails++; $display("FAIL sat_clr: got %0d expected 0", stall_cnt2); end
    stat_clr2 = 0; out_ready2 = 1;
    tick();
    tests++; if (stall_cnt2 !== 2'd0 || out_valid2 !== 1'b0) begin fails++; $display("FAIL sat_drain: got cnt=%0d valid=%b expected 0 0", stall_cnt2, out_valid2); end
  endtask

  task automatic test_rst_full();
    out_ready = 0; in_valid = 1; in_data = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL rst_full_prefill: got in_ready=%b valid=%b expected 0 1", in_ready, out_valid); end
    rst = 1; in_valid = 0;
    tick();
    tests++; if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0 || stall_cnt !== 16'd0) begin
      fails++; $display("FAIL rst_full: got valid=%b data=%h in_ready=%b stall=%0d expected 0 0 0 0", out_valid, out_data, in_ready, stall_cnt);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(99) == 0);
      flush    = ($urandom_range(15) == 0);
      stat_clr = ($urandom_range(31) == 0);
      in_valid = $urandom_range(1);
      out_ready = ($urandom_range(3) != 0) ? 1'b0 : 1'b1;
      if (i >= 200) out_ready = $urandom_range(1);
      in_data  = $urandom;
      tick();
      tests++;
      if (out_valid !== (q.size() > 0) || in_ready !== m_in_ready || out_data !== m_data || stall_cnt !== 16'(m_stall)) begin
        fails++;
        $display("FAIL random_%0d: got valid=%b ready=%b data=%h stall=%0d expected %b %b %h %0d",
                 i, out_valid, in_ready, out_data, stall_cnt, q.size() > 0, m_in_ready, m_data, m_stall);
      end
    end
    rst = 0; flush = 0; stat_clr = 0; in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall_saturate();
    test_rst_full();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline register that replaces the plain enable-gated stage register between pipeline stages of the RV32IM core. It carries a WIDTH-bit payload under a valid/ready handshake and adds a one-entry skid buffer so `in_ready` is fully registered, with no combinational path from `out_ready`. It also supports a flush that squashes in-flight entries on branch/jump redirect and a saturating stall-cycle counter for performance visibility.

## Interface
- `WIDTH`, 32: payload width in bits, ≥1.
- `CNT_W`, 16: stall counter width in bits, ≥2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `flush` in 1: squash all held entries; synchronous.
- `in_valid` in 1: upstream offers `in_data`.
- `in_ready` out 1: stage accepts; registered output.
- `in_data` in WIDTH: upstream payload.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out WIDTH: registered payload.
- `stat_clr` in 1: clears `stall_cnt` synchronously.
- `stall_cnt` out CNT_W: saturating count of cycles with `out_valid && !out_ready`.

## Operation
- Input transfer: `in_valid && in_ready` at a clock edge.
- Output transfer: `out_valid && out_ready` at a clock edge.
- Storage: main register (`out_data`/`out_valid`) and skid register (`skid_data`/`skid_valid`).
- State is encoded as EMPTY (no entries), BUSY (main only) or FULL (main + skid).
- EMPTY:
  - Input transfer loads main and moves to BUSY.
  - Otherwise stays in EMPTY.
- BUSY:
  - Input and output transfer: main ← `in_data`, stay BUSY.
  - Output transfer only: move to EMPTY.
  - Input transfer only: skid ← `in_data`, move to FULL.
  - Neither: hold.
- FULL:
  - `in_ready`=0.
  - Output transfer: main ← skid, move to BUSY.
  - Otherwise hold.
- `in_ready` next value = (next state ≠ FULL).
- Priority order: `rst` > `flush` > handshake.
- `flush`:
  - Next state is EMPTY; `out_valid`=0, `skid_valid`=0.
  - A concurrent input transfer is discarded.
  - Data registers keep their values.
  - `stall_cnt` is unaffected.
- `stall_cnt`:
  - `stat_clr` has priority over increment and sets the count to 0.
  - Otherwise increments on every cycle with `out_valid && !out_ready` and saturates at 2^CNT_W−1.
  - Increments are not suppressed by `flush` in the same cycle.
- Payload is never modified: no width conversion or sign extension.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `in_ready`=0, `stall_cnt`=0.
  - `skid_valid`=0, skid data 0, state EMPTY.
- `in_ready` rises at the first clock edge with `rst` low. No transfer is possible in the first post-reset cycle.
- Latency: input accepted at edge N is presented on `out_data` after edge N (visible in cycle N+1).
- Throughput: one transfer per cycle sustained while `out_ready`=1.
- Backpressure: after `out_ready` drops, at most one further input is accepted (into skid); `in_ready` is 0 from the following cycle.
- Ordering: strict FIFO; skid drains into main before any new input is accepted.
- `rst` asserted mid-operation: all entries are lost at that edge and the outputs take their reset values.
- `flush` and `in_valid` in the same cycle: input discarded, but `in_ready` is 1 the next cycle.
- Simultaneous `flush` and `out_ready`: any output transfer counts downstream; internally the entry is gone either way.

## Structure
- Shared package `pipe_pkg`: `typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_t`.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `rst`, `clr`, `inc`, `cnt`) for `stall_cnt`; reusable for other perf counters.
- The FSM, main register and skid register live in `pipe_skid_reg` itself.

## Test plan
- Reset release with `in_valid`=1, `in_data`=0xDEADBEEF:
  - Required: `in_ready`=0 in the first post-reset cycle, 1 in the next.
  - Required: `out_data`=0xDEADBEEF one cycle after acceptance.
- Streaming 0x1..0x8 with `out_ready`=1 constantly:
  - Required: 8 outputs on consecutive cycles, in order, one cycle behind input.
  - Required: `stall_cnt`=0.
- `out_ready` low for 3 cycles while streaming 0xA, 0xB, 0xC:
  - Required: 0xA held on output, 0xB captured in skid, `in_ready`=0 for the stall.
  - Required: on release the output order is A, B, C with no loss or duplication; `stall_cnt`=3.
- `flush` in FULL state while `in_valid`=1 with 0x55:
  - Required: `out_valid`=0 next cycle, `in_ready`=1 next cycle.
  - Required: 0x55 never appears on the output.
- `out_ready` held 0 with `CNT_W`=2 for 6 cycles:
  - Required: `stall_cnt` reaches 3 and stays at 3.
  - `stat_clr` pulse: required `stall_cnt`=0 next cycle.
- `rst` pulsed while FULL:
  - Required: next cycle `out_valid`=0, `out_data`=0, `in_ready`=0, `stall_cnt`=0.
